// File: rtl/char_term_ctrl_if.sv
// char_term_ctrl_if: byte-stream handshake, character-buffer ports and cursor/status for char_term_ctrl
interface char_term_ctrl_if #(
  parameter int ADDR_W = 13
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              buf_we;
  logic [ADDR_W-1:0] buf_waddr;
  logic [7:0]        buf_wdata;
  logic [ADDR_W-1:0] buf_raddr;
  logic [7:0]        buf_rdata;
  logic [6:0]        cur_col;
  logic [5:0]        cur_row;
  logic              busy;
  modport master (
    output in_data, in_valid, buf_rdata,
    input  in_ready, buf_we, buf_waddr, buf_wdata, buf_raddr, cur_col, cur_row, busy
  );
  modport slave (
    input  in_data, in_valid, buf_rdata,
    output in_ready, buf_we, buf_waddr, buf_wdata, buf_raddr, cur_col, cur_row, busy
  );
endinterface

// File: rtl/char_term_ctrl.sv
// char_term_ctrl: terminal sequencer owning the write side of a character buffer (define CHAR_TERM_TAB_EN for TAB stops)
module char_term_ctrl #(
  parameter int         COLS   = 80,
  parameter int         ROWS   = 40,
  parameter int         ADDR_W = 13,
  parameter logic [7:0] BLANK  = 8'h00
) (
  input logic            clk,
  input logic            rst,
  char_term_ctrl_if.slave bus
);
  localparam int CELLS = COLS * ROWS;
  localparam int N     = (ROWS - 1) * COLS;
  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_SCROLL, S_BLANK} state_t;
  state_t            state, state_d;
  logic [ADDR_W-1:0] cnt, cnt_d, waddr, waddr_d, raddr, raddr_d, cur_addr;
  logic [7:0]        wdata, wdata_d;
  logic              we, we_d;
  logic [6:0]        col, col_d;
  logic [5:0]        row, row_d, row_nl;
  logic              acc, is_cr, is_lf, is_bs, is_ff, is_tab, printable;
  logic              last_col, last_row, newline;
`ifdef CHAR_TERM_TAB_EN
  logic [7:0]        tab_col;
  logic              tab_wrap;
`endif
  assign acc       = bus.in_valid && state == S_IDLE;
  assign is_cr     = bus.in_data == 8'h0D;
  assign is_lf     = bus.in_data == 8'h0A;
  assign is_bs     = bus.in_data == 8'h08;
  assign is_ff     = bus.in_data == 8'h0C;
`ifdef CHAR_TERM_TAB_EN
  assign is_tab    = bus.in_data == 8'h09;
  assign tab_col   = {1'b0, col | 7'd7} + 8'd1;
  assign tab_wrap  = tab_col >= 8'(COLS);
`else
  assign is_tab    = 1'b0;
`endif
  assign printable = !(is_cr || is_lf || is_bs || is_ff || is_tab);
  assign last_col  = col == 7'(COLS - 1);
  assign last_row  = row == 6'(ROWS - 1);
  assign row_nl    = last_row ? row : row + 6'd1;
`ifdef CHAR_TERM_TAB_EN
  assign newline   = is_lf || (printable && last_col) || (is_tab && tab_wrap);
`else
  assign newline   = is_lf || (printable && last_col);
`endif
  assign cur_addr  = ADDR_W'(int'(row) * COLS + int'(col));
  assign bus.in_ready  = state == S_IDLE;
  assign bus.busy      = state != S_IDLE;
  assign bus.buf_we    = we;
  assign bus.buf_waddr = waddr;
  assign bus.buf_wdata = wdata;
  assign bus.buf_raddr = raddr;
  assign bus.cur_col   = col;
  assign bus.cur_row   = row;
  // State and datapath registers; reset aborts any operation and restarts with a full clear
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_CLEAR;
      cnt   <= '0;
      col   <= '0;
      row   <= '0;
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      raddr <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      col   <= col_d;
      row   <= row_d;
      we    <= we_d;
      waddr <= waddr_d;
      wdata <= wdata_d;
      raddr <= raddr_d;
    end
  // Next state: sweeps end on their last index, IDLE leaves only on FF or a bottom-row newline
  always_comb begin
    state_d = state;
    case (state)
      S_CLEAR:  state_d = cnt == ADDR_W'(CELLS - 1) ? S_IDLE : S_CLEAR;
      S_IDLE:   state_d = !acc ? S_IDLE : is_ff ? S_CLEAR : (newline && last_row) ? S_SCROLL : S_IDLE;
      S_SCROLL: state_d = cnt == ADDR_W'(N) ? S_BLANK : S_SCROLL;
      default:  state_d = cnt == ADDR_W'(COLS - 1) ? S_IDLE : S_BLANK;
    endcase
  end
  // Datapath: cursor update, registered buffer writes; SCROLL runs one extra cycle to drain the last copy
  always_comb begin
    cnt_d   = state_d != state ? '0 : cnt + ADDR_W'(1);
    col_d   = col;
    row_d   = row;
    we_d    = 1'b0;
    waddr_d = waddr;
    wdata_d = wdata;
    raddr_d = raddr;
    case (state)
      S_CLEAR: begin
        we_d    = 1'b1;
        waddr_d = cnt;
        wdata_d = BLANK;
      end
      S_IDLE: if (acc) begin
        if (is_cr) col_d = '0;
        else if (is_lf) row_d = row_nl;
        else if (is_bs) begin
          if (col != '0) begin
            col_d   = col - 7'd1;
            we_d    = 1'b1;
            waddr_d = cur_addr - ADDR_W'(1);
            wdata_d = BLANK;
          end
        end else if (is_ff) begin
          col_d = '0;
          row_d = '0;
        end
`ifdef CHAR_TERM_TAB_EN
        else if (is_tab) begin
          col_d = tab_wrap ? '0 : tab_col[6:0];
          row_d = tab_wrap ? row_nl : row;
        end
`endif
        else begin
          we_d    = 1'b1;
          waddr_d = cur_addr;
          wdata_d = bus.in_data;
          col_d   = last_col ? '0 : col + 7'd1;
          row_d   = last_col ? row_nl : row;
        end
        raddr_d = (newline && last_row) ? ADDR_W'(COLS) : raddr;
      end
      S_SCROLL: begin
        we_d    = cnt != '0;
        waddr_d = cnt - ADDR_W'(1);
        wdata_d = bus.buf_rdata;
        raddr_d = cnt < ADDR_W'(N - 1) ? raddr + ADDR_W'(1) : raddr;
      end
      default: begin
        we_d    = 1'b1;
        waddr_d = ADDR_W'(N) + cnt;
        wdata_d = BLANK;
      end
    endcase
  end
endmodule

// File: tb/tb_char_term_ctrl.sv
// tb_char_term_ctrl: directed scoreboard bench for char_term_ctrl with a synchronous buffer RAM model
module tb_char_term_ctrl;
  localparam int COLS = 80, ROWS = 40, ADDR_W = 13;
  localparam int CELLS = COLS * ROWS, N = (ROWS - 1) * COLS;
  typedef struct packed {logic [ADDR_W-1:0] a; logic [7:0] d;} wr_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pre_we = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [7:0] pre_data = '0;
  logic [7:0] mem [CELLS];
  logic [7:0] model [CELLS];
  wr_t q[$];
  int checks = 0, errors = 0;
  int er = 0, ec = 0;
  char_term_ctrl_if #(.ADDR_W(ADDR_W)) bus();
  char_term_ctrl #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .BLANK(8'h00)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus.buf_we) mem[bus.buf_waddr] <= bus.buf_wdata;
    bus.buf_rdata <= mem[bus.buf_raddr];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) if (!rst && bus.buf_we) begin
    wr_t w;
    checks++;
    assert (q.size() != 0) else begin
      errors++;
      $error("FAIL unexpected_write observed=%0h:%0h expected=none", bus.buf_waddr, bus.buf_wdata);
    end
    if (q.size() != 0) begin
      w = q.pop_front();
      chk("write", {11'b0, bus.buf_waddr, bus.buf_wdata}, {11'b0, w.a, w.d});
    end
  end
  function automatic void expect_wr(input int a, input logic [7:0] d);
    wr_t w;
    w.a = ADDR_W'(a);
    w.d = d;
    q.push_back(w);
    model[a] = d;
  endfunction
  function automatic void scroll_expect();
    for (int k = 0; k < N; k++) expect_wr(k, model[k + COLS]);
    for (int k = N; k < CELLS; k++) expect_wr(k, 8'h00);
  endfunction
  function automatic void clear_expect();
    for (int k = 0; k < CELLS; k++) expect_wr(k, 8'h00);
  endfunction
  function automatic void newline();
    if (er < ROWS - 1) er++;
    else scroll_expect();
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    int n = 0;
    bus.in_data = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 10000) begin
      tick();
      n++;
    end
    if (!bus.in_ready) chk("send_ready", {31'b0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask
  task automatic put(input logic [7:0] b);
    expect_wr(er * COLS + ec, b);
    if (ec == COLS - 1) begin
      ec = 0;
      newline();
    end else ec++;
    send(b);
  endtask
  task automatic lf();
    newline();
    send(8'h0A);
  endtask
  task automatic wait_idle(input string tag, input int exp);
    int n = 0;
    while (bus.busy && n < 10000) begin
      tick();
      n++;
    end
    chk(tag, n, exp);
  endtask
  task automatic cur(input string tag);
    chk({tag, "_col"}, {25'b0, bus.cur_col}, ec);
    chk({tag, "_row"}, {26'b0, bus.cur_row}, er);
  endtask
  task automatic drained(input string tag);
    tick();
    chk(tag, q.size(), 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (3) tick();
    chk("rst_busy", {31'b0, bus.busy}, 32'd1);
    chk("rst_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("rst_we", {31'b0, bus.buf_we}, 32'd0);
    chk("rst_waddr", {19'b0, bus.buf_waddr}, 32'd0);
    chk("rst_wdata", {24'b0, bus.buf_wdata}, 32'd0);
    chk("rst_raddr", {19'b0, bus.buf_raddr}, 32'd0);
    cur("rst");
    clear_expect();
    rst = 1'b0;
    wait_idle("clear_cycles", CELLS);
    chk("clear_ready", {31'b0, bus.in_ready}, 32'd1);
    cur("clear");
    drained("clear_drain");
    expect_wr(0, 8'h41);
    expect_wr(1, 8'h42);
    bus.in_data = 8'h41;
    bus.in_valid = 1'b1;
    tick();
    bus.in_data = 8'h42;
    tick();
    bus.in_valid = 1'b0;
    ec = 2;
    cur("ab");
    send(8'h0D);
    ec = 0;
    cur("cr");
    repeat (5) lf();
    for (int i = 0; i < 79; i++) put(8'(8'h20 + i));
    cur("row5_end");
    put(8'h5A);
    chk("wrap_busy", {31'b0, bus.busy}, 32'd0);
    cur("wrap");
    drained("wrap_drain");
    clear_expect();
    er = 0;
    ec = 0;
    send(8'h0C);
    wait_idle("ff_cycles", CELLS);
    cur("ff");
    repeat (3) lf();
    send(8'h08);
    cur("bs_col0");
    for (int i = 0; i < 10; i++) put(8'(8'h61 + i));
    expect_wr(249, 8'h00);
    ec = 9;
    send(8'h08);
    cur("bs_col10");
`ifdef CHAR_TERM_TAB_EN
    send(8'h09);
    ec = 16;
    cur("tab_mid");
    send(8'h0D);
    ec = 0;
    for (int i = 0; i < 77; i++) put(8'(8'h30 + i % 40));
    send(8'h09);
    ec = 0;
    er = er + 1;
    cur("tab_wrap");
`else
    put(8'h09);
    cur("tab_print");
`endif
    drained("edit_drain");
    while (er < ROWS - 1) lf();
    cur("bottom");
    pre_we = 1'b1;
    pre_addr = 13'd80;
    pre_data = 8'h11;
    tick();
    pre_addr = 13'd3199;
    pre_data = 8'h22;
    tick();
    pre_we = 1'b0;
    model[80] = 8'h11;
    model[3199] = 8'h22;
    lf();
    wait_idle("scroll_cycles", N + 1 + COLS);
    cur("scroll_lf");
    drained("scroll_drain");
    chk("mem0", {24'b0, mem[0]}, 32'h11);
    chk("mem3119", {24'b0, mem[3119]}, 32'h22);
    chk("mem3199", {24'b0, mem[3199]}, 32'h00);
    send(8'h0D);
    ec = 0;
    for (int i = 0; i < 79; i++) put(8'(8'h30 + i % 40));
    put(8'h5A);
    wait_idle("scroll_char_cycles", N + 1 + COLS);
    cur("scroll_char");
    drained("scroll_char_drain");
    chk("mem3119_z", {24'b0, mem[3119]}, 32'h5A);
    lf();
    repeat (100) tick();
    rst = 1'b1;
    #1;
    chk("abort_we", {31'b0, bus.buf_we}, 32'd0);
    chk("abort_busy", {31'b0, bus.busy}, 32'd1);
    chk("abort_ready", {31'b0, bus.in_ready}, 32'd0);
    q.delete();
    er = 0;
    ec = 0;
    repeat (2) tick();
    clear_expect();
    rst = 1'b0;
    wait_idle("abort_clear_cycles", CELLS);
    cur("abort_clear");
    drained("abort_drain");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
